// File: rtl/iir_mult_scheduler_if.sv
// Bus bundle for iir_mult_scheduler: sample requests/grants, configuration,
// the shared external multiplier and the result valid/ready port.
interface iir_mult_scheduler_if #(
   parameter int NCH = 4,
   parameter int CHW = 2
);
   logic [NCH-1:0]   req;
   logic [4*NCH-1:0] x_in;
   logic [NCH-1:0]   gnt;
   logic             cfg_we;
   logic             cfg_clr;
   logic [CHW-1:0]   cfg_ch;
   logic [3:0]       cfg_a;
   logic [3:0]       mult_a;
   logic [3:0]       mult_b;
   logic [7:0]       mult_p;
   logic             out_valid;
   logic             out_ready;
   logic [CHW-1:0]   out_ch;
   logic [3:0]       out_y;
   logic             busy;

   // scheduler side
   modport slave (
      input  req, x_in, cfg_we, cfg_clr, cfg_ch, cfg_a, mult_p, out_ready,
      output gnt, mult_a, mult_b, out_valid, out_ch, out_y, busy
   );

   // requester / multiplier / consumer side
   modport master (
      output req, x_in, cfg_we, cfg_clr, cfg_ch, cfg_a, mult_p, out_ready,
      input  gnt, mult_a, mult_b, out_valid, out_ch, out_y, busy
   );
endinterface

// File: rtl/iir_mult_scheduler.sv
// Shares one external 4x4 signed multiplier between NCH first-order IIR
// channels computing y[n] = x[n] + a*y[n-1] (4-bit wrap). Requests are served
// round-robin, one sample at a time: IDLE -> MUL -> ACC -> HOLD -> IDLE.
module iir_mult_scheduler #(
   parameter int NCH = 4,
   parameter int CHW = 2
) (
   input  logic clk,
   input  logic rst,
   iir_mult_scheduler_if.slave bus
);
   typedef enum logic [1:0] {IDLE, MUL, ACC, HOLD} state_t;

   state_t         state_q, state_d;
   logic [CHW-1:0] rr_q, rr_d;
   logic [CHW-1:0] ch_q, ch_d;
   logic [3:0]     x_q, x_d;
   logic [7:0]     p_q, p_d;
   logic [NCH-1:0] gnt_q, gnt_d;
   logic           out_valid_q, out_valid_d;
   logic [CHW-1:0] out_ch_q, out_ch_d;
   logic [3:0]     out_y_q, out_y_d;
   logic [3:0]     coef_q [NCH];
   logic [3:0]     coef_d [NCH];
   logic [3:0]     ys_q [NCH];
   logic [3:0]     ys_d [NCH];

   logic [3:0]     x_arr [NCH];
   logic           found;
   logic [CHW-1:0] win;
   int             idx;
   logic [3:0]     y_sum;
   logic           cfg_ok;

   // unpack per-channel samples
   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_x
         assign x_arr[gi] = bus.x_in[4*gi +: 4];
      end
   endgenerate

   // round-robin pick: first requesting channel at or after rr_q, wrapping
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int k = 0; k < NCH; k++) begin
         idx = (int'(rr_q) + k) % NCH;
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            win   = CHW'(idx);
         end
      end
   end

   // only the low product nibble matters: the sum wraps at 4 bits anyway
   assign y_sum  = x_q + p_q[3:0];
   assign cfg_ok = int'(bus.cfg_ch) < NCH;

   // next-state logic; config is applied after the ACC write so a clear wins
   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      ch_d        = ch_q;
      x_d         = x_q;
      p_d         = p_q;
      gnt_d       = '0;
      out_valid_d = out_valid_q;
      out_ch_d    = out_ch_q;
      out_y_d     = out_y_q;
      coef_d      = coef_q;
      ys_d        = ys_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               gnt_d[win] = 1'b1;
               x_d        = x_arr[win];
               ch_d       = win;
               rr_d       = (win == CHW'(NCH - 1)) ? '0 : win + 1'b1;
               state_d    = MUL;
            end
         end
         MUL: begin
            p_d     = bus.mult_p;
            state_d = ACC;
         end
         ACC: begin
            ys_d[ch_q]  = y_sum;
            out_y_d     = y_sum;
            out_ch_d    = ch_q;
            out_valid_d = 1'b1;
            state_d     = HOLD;
         end
         HOLD: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (cfg_ok) begin
         if (bus.cfg_we)  coef_d[bus.cfg_ch] = bus.cfg_a;
         if (bus.cfg_clr) ys_d[bus.cfg_ch]   = '0;
      end
   end

   // state register; reset drops any in-flight sample
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_q        <= '0;
         ch_q        <= '0;
         x_q         <= '0;
         p_q         <= '0;
         gnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         out_y_q     <= '0;
         for (int k = 0; k < NCH; k++) begin
            coef_q[k] <= '0;
            ys_q[k]   <= '0;
         end
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         ch_q        <= ch_d;
         x_q         <= x_d;
         p_q         <= p_d;
         gnt_q       <= gnt_d;
         out_valid_q <= out_valid_d;
         out_ch_q    <= out_ch_d;
         out_y_q     <= out_y_d;
         coef_q      <= coef_d;
         ys_q        <= ys_d;
      end
   end

   // operands are only presented during MUL so the multiplier sees zeros otherwise
   assign bus.mult_a    = (state_q == MUL) ? coef_q[ch_q] : 4'd0;
   assign bus.mult_b    = (state_q == MUL) ? ys_q[ch_q]   : 4'd0;
   assign bus.gnt       = gnt_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.out_y     = out_y_q;
   assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_iir_mult_scheduler.sv
// Bench for iir_mult_scheduler: directed scenarios plus randomized samples
// and config traffic, checked against a transaction-level filter model.
module tb_iir_mult_scheduler;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   iir_mult_scheduler_if #(.NCH(4), .CHW(2)) mif ();
   iir_mult_scheduler_if #(.NCH(3), .CHW(2)) s3 ();

   iir_mult_scheduler #(.NCH(4), .CHW(2)) u_dut (.clk(clk), .rst(rst), .bus(mif.slave));
   iir_mult_scheduler #(.NCH(3), .CHW(2)) u_dut3 (.clk(clk), .rst(rst), .bus(s3.slave));

   // external signed multiplier: sign-extend both operands, keep 8 bits
   assign mif.mult_p = {{4{mif.mult_a[3]}}, mif.mult_a} * {{4{mif.mult_b[3]}}, mif.mult_b};
   assign s3.mult_p  = {{4{s3.mult_a[3]}}, s3.mult_a} * {{4{s3.mult_b[3]}}, s3.mult_b};

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic [3:0] coef_m [4];
   logic [3:0] ys_m [4];
   int         rr_m;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int sx4(input logic [3:0] v);
      return v[3] ? int'(v) - 16 : int'(v);
   endfunction

   function automatic logic [3:0] filt(input logic [3:0] x, input logic [3:0] a, input logic [3:0] yp);
      int t;
      t = sx4(x) + sx4(a) * sx4(yp);
      return 4'(t);
   endfunction

   function automatic int pick(input logic [3:0] rq, input int rr);
      for (int k = 0; k < 4; k++)
         if (rq[(rr + k) % 4]) return (rr + k) % 4;
      return 0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         coef_m[k] = 4'd0;
         ys_m[k]   = 4'd0;
      end
      rr_m = 0;
   endtask

   task automatic model_cfg(input logic we, input logic clr, input logic [1:0] ch, input logic [3:0] a);
      if (we)  coef_m[ch] = a;
      if (clr) ys_m[ch]   = 4'd0;
   endtask

   task automatic cfg_drive(input logic we, input logic clr, input logic [1:0] ch, input logic [3:0] a);
      mif.cfg_we  = we;
      mif.cfg_clr = clr;
      mif.cfg_ch  = ch;
      mif.cfg_a   = a;
   endtask

   task automatic cfg_off();
      mif.cfg_we  = 1'b0;
      mif.cfg_clr = 1'b0;
   endtask

   // one config write while idle
   task automatic cfg_idle(input logic we, input logic clr, input logic [1:0] ch, input logic [3:0] a);
      cfg_drive(we, clr, ch, a);
      model_cfg(we, clr, ch, a);
      @(posedge clk); #1;
      cfg_off();
   endtask

   // one complete sample; cph selects the cycle of an optional config write
   // (1 = grant cycle, 2 = MUL cycle, 3 = ACC cycle)
   task automatic txn(input logic [3:0] rq, input logic [15:0] xv, input int hold_cyc,
                      input int cph, input logic we, input logic clr,
                      input logic [1:0] cch, input logic [3:0] ca, output logic [3:0] y_obs);
      int w;
      logic [3:0] y_e;
      w = pick(rq, rr_m);
      mif.req  = rq;
      mif.x_in = xv;
      check("idle_mult_a", mif.mult_a, 0);
      if (cph == 1) begin cfg_drive(we, clr, cch, ca); model_cfg(we, clr, cch, ca); end
      @(posedge clk); #1;
      cfg_off();
      check("gnt", mif.gnt, 32'(1) << w);
      check("busy_mul", mif.busy, 1);
      mif.req = 4'd0;
      check("mult_a", mif.mult_a, coef_m[w]);
      check("mult_b", mif.mult_b, ys_m[w]);
      y_e = filt(xv[4*w +: 4], coef_m[w], ys_m[w]);
      if (cph == 2) begin cfg_drive(we, clr, cch, ca); model_cfg(we, clr, cch, ca); end
      @(posedge clk); #1;
      cfg_off();
      check("valid_early", mif.out_valid, 0);
      check("gnt_pulse", mif.gnt, 0);
      ys_m[w] = y_e;
      rr_m    = (w + 1) % 4;
      if (cph == 3) begin cfg_drive(we, clr, cch, ca); model_cfg(we, clr, cch, ca); end
      mif.out_ready = (hold_cyc == 0);
      @(posedge clk); #1;
      cfg_off();
      check("valid_lat2", mif.out_valid, 1);
      check("out_y", mif.out_y, y_e);
      check("out_ch", mif.out_ch, w);
      y_obs = mif.out_y;
      if (hold_cyc > 0) begin
         mif.req = 4'hF;
         for (int i = 0; i < hold_cyc; i++) begin
            @(posedge clk); #1;
            check("hold_valid", mif.out_valid, 1);
            check("hold_y", mif.out_y, y_e);
            check("hold_ch", mif.out_ch, w);
            check("hold_gnt", mif.gnt, 0);
            check("hold_busy", mif.busy, 1);
         end
         mif.req = 4'd0;
      end
      mif.out_ready = 1'b1;
      @(posedge clk); #1;
      check("valid_drop", mif.out_valid, 0);
      check("busy_idle", mif.busy, 0);
      mif.out_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   logic [3:0] y_obs;
   logic [3:0] exp1 [5];
   logic [3:0] exp2 [3];
   int gcnt, last_cyc, ocnt;
   logic [3:0] rq_r;
   logic [15:0] x_r;

   initial begin
      mif.req = '0; mif.x_in = '0; mif.out_ready = 1'b0; cfg_drive(0, 0, 0, 0);
      s3.req = '0; s3.x_in = '0; s3.out_ready = 1'b0;
      s3.cfg_we = 1'b0; s3.cfg_clr = 1'b0; s3.cfg_ch = '0; s3.cfg_a = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_gnt", mif.gnt, 0);
      check("rst_valid", mif.out_valid, 0);
      check("rst_busy", mif.busy, 0);
      check("rst_y", mif.out_y, 0);
      check("rst_ch", mif.out_ch, 0);
      check("rst_mult", {mif.mult_a, mif.mult_b}, 0);
      rst = 1'b0;

      // all requests high straight from reset: 0,1,2,3,0, four cycles apart
      mif.req = 4'hF; mif.out_ready = 1'b1; mif.x_in = 16'h4321;
      gcnt = 0; last_cyc = 0;
      for (int c = 1; c <= 18; c++) begin
         @(posedge clk); #1;
         if (mif.gnt != 0) begin
            check("rr_order", mif.gnt, 32'(1) << (gcnt % 4));
            if (gcnt > 0) check("rr_spacing", c - last_cyc, 4);
            last_cyc = c;
            gcnt++;
         end
      end
      check("rr_count", gcnt, 5);
      mif.req = 4'd0; mif.out_ready = 1'b0;
      do_reset();

      // ch0 a=2, x=1
      exp1 = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hF};
      cfg_idle(1, 1, 0, 4'h2);
      for (int i = 0; i < 5; i++) begin
         txn(4'b0001, 16'h0001, 0, 0, 0, 0, 0, 0, y_obs);
         check("t1_y", y_obs, exp1[i]);
      end

      // ch1 a=-1, x=3
      exp2 = '{4'h3, 4'h0, 4'h3};
      cfg_idle(1, 1, 1, 4'hF);
      for (int i = 0; i < 3; i++) begin
         txn(4'b0010, 16'h0030, 0, 0, 0, 0, 0, 0, y_obs);
         check("t2_y", y_obs, exp2[i]);
      end

      // back-pressure for six cycles, then a follow-on grant
      txn(4'b0100, 16'h0500, 6, 0, 0, 0, 0, 0, y_obs);
      txn(4'b1000, 16'h6000, 0, 0, 0, 0, 0, 0, y_obs);

      // clearing a channel state of 7
      cfg_idle(1, 1, 0, 4'h0);
      txn(4'b0001, 16'h0007, 0, 0, 0, 0, 0, 0, y_obs);
      check("t5_seed", y_obs, 4'h7);
      cfg_idle(1, 1, 0, 4'h2);
      txn(4'b0001, 16'h0001, 0, 0, 0, 0, 0, 0, y_obs);
      check("t5_y", y_obs, 4'h1);

      // randomized samples with config traffic in every phase
      for (int i = 0; i < 120; i++) begin
         rq_r = 4'($urandom_range(1, 15));
         x_r  = 16'($urandom);
         txn(rq_r, x_r, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
             int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             2'($urandom), 4'($urandom), y_obs);
      end

      // reset during ACC drops the sample
      mif.req = 4'b0001; mif.x_in = 16'h0001;
      @(posedge clk); #1;
      mif.req = 4'd0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("t6_valid", mif.out_valid, 0);
      check("t6_busy", mif.busy, 0);
      rst = 1'b0;
      model_reset();
      txn(4'b0001, 16'h0001, 0, 0, 0, 0, 0, 0, y_obs);
      check("t6_y", y_obs, 4'h1);

      // three-channel instance: out-of-range config is ignored, rr wraps at 3
      s3.cfg_we = 1'b1; s3.cfg_clr = 1'b1; s3.cfg_ch = 2'd3; s3.cfg_a = 4'h2;
      @(posedge clk); #1;
      s3.cfg_we = 1'b0; s3.cfg_clr = 1'b0;
      s3.req = 3'b111; s3.x_in = 12'h111; s3.out_ready = 1'b1;
      gcnt = 0; ocnt = 0;
      for (int c = 1; c <= 18; c++) begin
         @(posedge clk); #1;
         if (s3.gnt != 0) begin
            check("n3_gnt", s3.gnt, 32'(1) << (gcnt % 3));
            gcnt++;
         end
         if (s3.out_valid) begin
            check("n3_y", s3.out_y, 4'h1);
            check("n3_ch", s3.out_ch, ocnt % 3);
            ocnt++;
         end
      end
      check("n3_count", gcnt, 5);
      s3.req = '0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
